// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the product accumulator and the sum consumer.
// The master side drives terms and consumes sums; the slave side is the accumulator.
interface product_accumulator_if #(
    parameter int ACC_W = 16
);
    logic [7:0]       p;
    logic             pValid;
    logic             pReady;
    logic             clear;
    logic [ACC_W-1:0] sum;
    logic             sumValid;
    logic             sumReady;
    logic [3:0]       count;
    logic             overflow;

    modport master (
        output p, pValid, clear, sumReady,
        input  pReady, sum, sumValid, count, overflow
    );

    modport slave (
        input  p, pValid, clear, sumReady,
        output pReady, sum, sumValid, count, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 8-bit products into an ACC_W-bit accumulator and presents the batch total.
// Optional feature: define ACC_SAT_EN to saturate Sum to all ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    product_accumulator_if.slave bus
);

    typedef enum logic {
        ACCUM,
        DONE
    } state_e;

    localparam logic [3:0] LAST = 4'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   addFull;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Clear outranks both a term handshake and a consume in the same cycle.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        addFull = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, bus.p};
        if (bus.clear) begin
            state_d = ACCUM;
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.pValid) begin
                        count_d = count_q + 4'd1;
                        ovf_d   = ovf_q | addFull[ACC_W];
`ifdef ACC_SAT_EN
                        sum_d   = ovf_d ? '1 : addFull[ACC_W-1:0];
`else
                        sum_d   = addFull[ACC_W-1:0];
`endif
                        if (count_q == LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.sumReady) begin
                        state_d = ACCUM;
                        sum_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.pReady   = (state_q == ACCUM);
        bus.sumValid = (state_q == DONE);
        bus.sum      = sum_q;
        bus.count    = count_q;
        bus.overflow = ovf_q;
    end

endmodule
